// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle between two requesting masters, the round-robin arbiter and the shared slave.
// master modport = request/response environment side; slave modport = arbiter side.
interface mem_rr_arbiter_if;
   logic        m0_valid;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic [3:0]  m0_wstrb;
   logic        m0_ready;
   logic [31:0] m0_rdata;
   logic        m0_err;

   logic        m1_valid;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic [3:0]  m1_wstrb;
   logic        m1_ready;
   logic [31:0] m1_rdata;
   logic        m1_err;

   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_ready;
   logic [31:0] s_rdata;

   modport master (
      output m0_valid, m0_addr, m0_wdata, m0_wstrb,
      output m1_valid, m1_addr, m1_wdata, m1_wstrb,
      output s_ready, s_rdata,
      input  m0_ready, m0_rdata, m0_err,
      input  m1_ready, m1_rdata, m1_err,
      input  s_valid, s_addr, s_wdata, s_wstrb
   );

   modport slave (
      input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
      input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
      input  s_ready, s_rdata,
      output m0_ready, m0_rdata, m0_err,
      output m1_ready, m1_rdata, m1_err,
      output s_valid, s_addr, s_wdata, s_wstrb
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-master round-robin arbiter onto one shared slave: 1-cycle grant latency, one RECOVER cycle per transfer.
// Losing master is held pending without ready; ARB_TIMEOUT_EN adds a slave-response watchdog.
module mem_rr_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            resetn,
   mem_rr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, RECOVER} state_t;

   state_t state;
   logic   last_served;
   logic   gnt0;
   logic   gnt1;
   logic   req;
   logic   done;
   logic   tmo;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_rr_arbiter: TIMEOUT_CYCLES outside 2..65535");
   end

   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);
   assign req  = (gnt0 && bus.m0_valid) || (gnt1 && bus.m1_valid);
   assign done = req && (bus.s_ready || tmo);

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt;

   // s_ready in the expiry cycle wins: tmo only fires while the slave is silent
   assign tmo = req && !bus.s_ready && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!resetn || state == IDLE) begin
         tmo_cnt <= '0;
      end else if ((gnt0 || gnt1) && !bus.s_ready) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         last_served <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.m0_valid && (!bus.m1_valid || last_served)) begin
                  state       <= GNT0;
                  last_served <= 1'b0;
               end else if (bus.m1_valid) begin
                  state       <= GNT1;
                  last_served <= 1'b1;
               end
            end
            // a master dropping valid mid-grant is abandoned without a ready pulse
            GNT0, GNT1: begin
               if (!req || done) state <= RECOVER;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.s_valid = req;
      bus.s_addr  = '0;
      bus.s_wdata = '0;
      bus.s_wstrb = '0;
      if (gnt0 && bus.m0_valid) begin
         bus.s_addr  = bus.m0_addr;
         bus.s_wdata = bus.m0_wdata;
         bus.s_wstrb = bus.m0_wstrb;
      end else if (gnt1 && bus.m1_valid) begin
         bus.s_addr  = bus.m1_addr;
         bus.s_wdata = bus.m1_wdata;
         bus.s_wstrb = bus.m1_wstrb;
      end
   end

   assign bus.m0_ready = gnt0 && done;
   assign bus.m1_ready = gnt1 && done;
   assign bus.m0_rdata = !bus.m0_ready ? 32'h0 : (tmo ? 32'hFFFF_FFFF : bus.s_rdata);
   assign bus.m1_rdata = !bus.m1_ready ? 32'h0 : (tmo ? 32'hFFFF_FFFF : bus.s_rdata);
   assign bus.m0_err   = bus.m0_ready && tmo;
   assign bus.m1_err   = bus.m1_ready && tmo;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter; completions are matched against a queue of expected responses.
module tb_mem_rr_arbiter;

   typedef struct packed {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic resetn;
   int   total;
   int   bad;
   exp_t sb[$];
   exp_t mon_e;

   mem_rr_arbiter_if bus ();

   mem_rr_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic port, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.port  = port;
      e.rdata = rdata;
      e.err   = err;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      cyc();
      cyc();
      resetn = 1'b1;
   endtask

   // Every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.m0_ready || bus.m1_ready) begin
         chk("ready_exclusive", {31'b0, bus.m0_ready & bus.m1_ready}, 32'd0);
         if (sb.size() == 0) begin
            chk("spurious_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("ready_port", {30'b0, bus.m1_ready, bus.m0_ready}, mon_e.port ? 32'd2 : 32'd1);
            chk("rdata", mon_e.port ? bus.m1_rdata : bus.m0_rdata, mon_e.rdata);
            chk("err", {31'b0, mon_e.port ? bus.m1_err : bus.m0_err}, {31'b0, mon_e.err});
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      resetn = 1'b0;
      bus.m0_valid = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
      bus.m1_valid = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
      bus.s_ready  = 0; bus.s_rdata = 0;
      cyc();
      cyc();
      #1;
      chk("rst_s_valid", {31'b0, bus.s_valid}, 32'd0);
      chk("rst_s_addr", bus.s_addr, 32'd0);
      chk("rst_s_wstrb", {28'b0, bus.s_wstrb}, 32'd0);
      chk("rst_m0_ready", {31'b0, bus.m0_ready}, 32'd0);
      chk("rst_m1_rdata", bus.m1_rdata, 32'd0);
      resetn = 1'b1;
      cyc();

      // m0 read, slave answers on the third grant cycle
      bus.m0_valid = 1; bus.m0_addr = 32'h2010_0000; bus.m0_wstrb = 4'b0000;
      #1 chk("rd_sval_idle", {31'b0, bus.s_valid}, 32'd0);
      cyc();
      chk("rd_sval_gnt", {31'b0, bus.s_valid}, 32'd1);
      chk("rd_s_addr", bus.s_addr, 32'h2010_0000);
      chk("rd_s_wstrb", {28'b0, bus.s_wstrb}, 32'd0);
      cyc();
      chk("rd_wait_ready", {31'b0, bus.m0_ready}, 32'd0);
      cyc();
      bus.s_ready = 1; bus.s_rdata = 32'hDEAD_BEEF;
      push(1'b0, 32'hDEAD_BEEF, 1'b0);
      #1 chk("rd_m0_ready", {31'b0, bus.m0_ready}, 32'd1);
      chk("rd_m1_ready", {31'b0, bus.m1_ready}, 32'd0);
      cyc();
      bus.m0_valid = 0; bus.s_ready = 0;
      #1 chk("rd_recover_sval", {31'b0, bus.s_valid}, 32'd0);
      chk("rd_recover_ready", {31'b0, bus.m0_ready}, 32'd0);
      cyc();

      // simultaneous continuous requests from reset alternate m0,m1,...
      do_reset();
      bus.m0_valid = 1; bus.m0_addr = 32'h0000_0A00;
      bus.m1_valid = 1; bus.m1_addr = 32'h0000_0B00;
      for (int t = 0; t < 8; t++) begin
         #1 chk("rr_idle_sval", {31'b0, bus.s_valid}, 32'd0);
         cyc();
         chk("rr_gnt_sval", {31'b0, bus.s_valid}, 32'd1);
         chk("rr_gnt_addr", bus.s_addr, (t % 2 == 1) ? 32'h0000_0B00 : 32'h0000_0A00);
         bus.s_ready = 1; bus.s_rdata = 32'h1000 + 32'(t);
         push(t % 2 == 1, 32'h1000 + 32'(t), 1'b0);
         #1;
         cyc();
         bus.s_ready = 0;
         #1 chk("rr_recover_sval", {31'b0, bus.s_valid}, 32'd0);
         cyc();
      end
      bus.m0_valid = 0; bus.m1_valid = 0;
      cyc();

      // m1 write passes fields through; stray s_ready in IDLE is ignored
      bus.s_ready = 1; bus.s_rdata = 32'h7777_7777;
      #1 chk("idle_stray_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd0);
      cyc();
      bus.s_ready = 0;
      bus.m1_valid = 1; bus.m1_addr = 32'h3000_0040; bus.m1_wdata = 32'h0000_1234; bus.m1_wstrb = 4'b0011;
      cyc();
      chk("wr_s_wstrb", {28'b0, bus.s_wstrb}, 32'h3);
      chk("wr_s_wdata", bus.s_wdata, 32'h0000_1234);
      chk("wr_s_addr", bus.s_addr, 32'h3000_0040);
      cyc();
      bus.s_ready = 1; bus.s_rdata = 32'h0000_5555;
      push(1'b1, 32'h0000_5555, 1'b0);
      #1 chk("wr_m1_ready", {31'b0, bus.m1_ready}, 32'd1);
      cyc();
      bus.m1_valid = 0; bus.m1_wstrb = 0; bus.s_ready = 0;
      cyc();

      // reset during GNT1 clears everything; stray s_ready afterwards is ignored
      bus.m1_valid = 1; bus.m1_addr = 32'h4000_0000;
      cyc();
      chk("rstmid_sval_before", {31'b0, bus.s_valid}, 32'd1);
      resetn = 0;
      cyc();
      chk("rstmid_sval", {31'b0, bus.s_valid}, 32'd0);
      chk("rstmid_saddr", bus.s_addr, 32'd0);
      chk("rstmid_swdata", bus.s_wdata, 32'd0);
      bus.m1_valid = 0; resetn = 1; bus.s_ready = 1;
      #1 chk("rstmid_stray", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd0);
      cyc();
      bus.s_ready = 0;
      cyc();

      // m0 abandons its request mid-grant: no ready, stray s_ready in RECOVER ignored
      bus.m0_valid = 1; bus.m0_addr = 32'h5000_0000;
      cyc();
      bus.m0_valid = 0;
      #1 chk("viol_sval_drop", {31'b0, bus.s_valid}, 32'd0);
      cyc();
      bus.s_ready = 1;
      #1 chk("viol_recover_ready", {30'b0, bus.m1_ready, bus.m0_ready}, 32'd0);
      cyc();
      bus.s_ready = 0;
      cyc();

      // m1 arrives during m0 service and is served next, not lost
      bus.m0_valid = 1; bus.m0_addr = 32'h0000_0040;
      cyc();
      bus.m1_valid = 1; bus.m1_addr = 32'h0000_0080;
      #1 chk("pend_addr_m0", bus.s_addr, 32'h0000_0040);
      cyc();
      bus.s_ready = 1; bus.s_rdata = 32'h0000_0011;
      push(1'b0, 32'h0000_0011, 1'b0);
      #1;
      cyc();
      bus.m0_valid = 0; bus.s_ready = 0;
      #1 chk("pend_m1_wait", {31'b0, bus.m1_ready}, 32'd0);
      cyc();
      cyc();
      chk("pend_addr_m1", bus.s_addr, 32'h0000_0080);
      bus.s_ready = 1; bus.s_rdata = 32'h0000_0022;
      push(1'b1, 32'h0000_0022, 1'b0);
      #1;
      cyc();
      bus.m1_valid = 0; bus.s_ready = 0;
      cyc();

`ifdef ARB_TIMEOUT_EN
      // silent slave: error completion on the 8th cycle with s_valid high
      bus.m0_valid = 1; bus.m0_addr = 32'h6000_0000;
      cyc();
      push(1'b0, 32'hFFFF_FFFF, 1'b1);
      for (int k = 0; k < 7; k++) begin
         #1 chk("tmo_wait", {31'b0, bus.m0_ready}, 32'd0);
         cyc();
      end
      chk("tmo_ready", {31'b0, bus.m0_ready}, 32'd1);
      chk("tmo_err", {31'b0, bus.m0_err}, 32'd1);
      chk("tmo_rdata", bus.m0_rdata, 32'hFFFF_FFFF);
      cyc();
      bus.m0_valid = 0;
      cyc();
`else
      // silent slave: grant is held indefinitely, never an error
      bus.m0_valid = 1; bus.m0_addr = 32'h6000_0000;
      cyc();
      for (int k = 0; k < 120; k++) begin
         #1 chk("notmo_sval", {31'b0, bus.s_valid}, 32'd1);
         chk("notmo_err", {31'b0, bus.m0_err}, 32'd0);
         cyc();
      end
      bus.s_ready = 1; bus.s_rdata = 32'hCAFE_F00D;
      push(1'b0, 32'hCAFE_F00D, 1'b0);
      #1;
      cyc();
      bus.m0_valid = 0; bus.s_ready = 0;
      cyc();
`endif

      cyc();
      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, slave-response watchdog limit in clk cycles; legal range 2..65535.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port resetn  input  1  reset, synchronous, active-low.
REQ-004 Ports m0_valid, m1_valid  input  1  request from master N (m0 = CPU, m1 = DMA/secondary); held high until mN_ready is seen.
REQ-005 Ports m0_addr, m1_addr  input  32  byte address of master N.
REQ-006 Ports m0_wdata, m1_wdata  input  32  write data of master N.
REQ-007 Ports m0_wstrb, m1_wstrb  input  4  byte write strobes; 4'b0000 = read.
REQ-008 Ports m0_ready, m1_ready  output  1  single-cycle completion pulse to master N.
REQ-009 Ports m0_rdata, m1_rdata  output  32  read data, valid only while mN_ready = 1, else 0.
REQ-010 Ports m0_err, m1_err  output  1  timeout error flag, qualified by mN_ready.
REQ-011 Port s_valid  output  1  request to shared slave (SDRAM/flash controller).
REQ-012 Ports s_addr, s_wdata, s_wstrb  output  32/32/4  muxed request fields of granted master; 0 when idle.
REQ-013 Port s_ready  input  1  single-cycle slave completion pulse; ignored unless s_valid = 1.
REQ-014 Port s_rdata  input  32  slave read data, sampled when s_ready = 1.

Function
REQ-015 FSM states IDLE, GNT0, GNT1, RECOVER; state and grant are registered.
REQ-016 IDLE: m0_valid only -> GNT0; m1_valid only -> GNT1; both -> master other than last_served; none -> IDLE.
REQ-017 last_served (1 bit) updates to N on entry to GNTN; round-robin guarantees each master waits at most one other transaction.
REQ-018 s_valid = 1 in GNTN while mN_valid = 1; request fields muxed from master N; s_valid asserts the cycle after mN_valid is first sampled in IDLE (1-cycle arbitration latency).
REQ-019 In GNTN, s_ready = 1 -> same-cycle mN_ready = 1, mN_rdata = s_rdata, mN_err = 0; next state RECOVER.
REQ-020 RECOVER lasts exactly one cycle with s_valid = 0, then IDLE; lets masters drop valid and slaves clear ready; back-to-back requests therefore issue every third cycle minimum.
REQ-021 mN_valid deasserting in GNTN before completion is a protocol violation; arbiter drops s_valid and goes to RECOVER without pulsing mN_ready.
REQ-022 The non-granted master never sees ready; its request is held pending, not lost.
REQ-023 m0_ready and m1_ready are never high in the same cycle; s_ready in IDLE or RECOVER produces no master ready.

Reset
REQ-024 resetn = 0 at any clk edge, including mid-transaction: state -> IDLE, last_served -> 1 (m0 wins first tie), timeout counter -> 0.
REQ-025 During and after reset until next grant: s_valid, s_addr, s_wdata, s_wstrb, mN_ready, mN_rdata, mN_err all 0.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN enables a 16-bit watchdog counter cleared on GNTN entry and incremented each GNTN cycle without s_ready.
REQ-027 With ARB_TIMEOUT_EN: counter reaching TIMEOUT_CYCLES-1 without s_ready -> mN_ready = 1, mN_err = 1, mN_rdata = 32'hFFFF_FFFF that cycle, then RECOVER; s_ready in the same cycle takes precedence (normal completion, err = 0).
REQ-028 Without ARB_TIMEOUT_EN: no counter instantiated, m0_err/m1_err tied 0, GNTN waits indefinitely for s_ready.

Verification
REQ-029 m0 read addr 32'h2010_0000, slave s_ready after 3 cycles with s_rdata 32'hDEAD_BEEF -> s_valid rises 1 cycle after m0_valid, m0_ready 1-cycle pulse with rdata DEAD_BEEF, m1_ready stays 0.
REQ-030 m0 and m1 valid same cycle from reset -> m0 served first, m1 granted after RECOVER+IDLE; repeat continuous requests -> strict alternation m0,m1,m0,m1 over 8 transactions.
REQ-031 m1 write wstrb 4'b0011 wdata 32'h0000_1234 -> s_wstrb 4'b0011, s_wdata 32'h0000_1234, s_addr = m1_addr while granted; m1_ready on s_ready.
REQ-032 resetn pulsed low during GNT1 with s_valid high -> next cycle all outputs 0, state IDLE; stray s_ready afterward yields no master ready.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never responds -> m0_ready and m0_err pulse 8 cycles after s_valid rises, rdata FFFF_FFFF; without macro, s_valid stays high 100+ cycles, m0_err always 0.
